// File: rtl/pwm_ctrl_pkg.sv
// Shared types, widths and step arithmetic for the PWM ramp controller.
package pwm_ctrl_pkg;

   localparam int unsigned DUTY_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } ramp_state_e;

   // Latched ramp command payload.
   typedef struct packed {
      logic [DUTY_W-1:0] target;
      logic [DUTY_W-1:0] step;
   } ramp_cfg_t;

   // One step of duty toward target, clamped at target; 33-bit math so
   // neither direction can wrap. A zero step jumps straight to target.
   function automatic logic [DUTY_W-1:0] step_toward(
      input logic [DUTY_W-1:0] duty,
      input logic [DUTY_W-1:0] target,
      input logic [DUTY_W-1:0] step
   );
      logic [DUTY_W:0]   wide;
      logic [DUTY_W-1:0] res;
      res  = target;
      wide = '0;
      if (step != '0) begin
         if (duty < target) begin
            wide = {1'b0, duty} + {1'b0, step};
            if (wide < {1'b0, target}) res = wide[DUTY_W-1:0];
         end else if (duty > target) begin
            wide = {1'b0, duty} - {1'b0, step};
            if (!wide[DUTY_W] && (wide[DUTY_W-1:0] > target)) res = wide[DUTY_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// PWM frame timer: free-running frame counter gated by enable, registered
// run flag (PWM enable), frame_start pulse and a frame-wrap strobe.
// The counter only advances once run is high, so a PWM enabled by run_o
// starts its own counter at 0 in lockstep with this one.
module pwm_frame_timer #(
   parameter int unsigned CLK_PERIOD = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   output logic run_o,
   output logic frame_start_o,
   output logic wrap_c_o
);

   localparam int unsigned CW = (CLK_PERIOD > 1) ? $clog2(CLK_PERIOD) : 1;

   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fs_q, fs_d;
   logic          last_c;

   assign last_c = (cnt_q == CW'(CLK_PERIOD - 1));

   // Next counter value; frame_start precomputed from the next count.
   always_comb begin
      run_d = enable_i;
      cnt_d = '0;
      if (enable_i && run_q) begin
         cnt_d = last_c ? '0 : cnt_q + CW'(1);
      end
      fs_d = enable_i && (cnt_d == '0);
   end

   // Timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         fs_q  <= fs_d;
      end
   end

   assign run_o         = run_q;
   assign frame_start_o = fs_q;
   assign wrap_c_o      = run_q && enable_i && last_c;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: accepts ramp commands and walks the duty value
// toward the target one step per N frames, updating only at frame wrap.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int unsigned CLK_PERIOD = 1000,
   parameter int unsigned FW         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [DUTY_W-1:0] cmd_step,
   input  logic [FW-1:0]     cmd_frames,
   output logic [DUTY_W-1:0] duty,
   output logic              pwm_en,
   output logic              frame_start,
   output logic              busy,
   output logic              done
);

   ramp_state_e       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   ramp_cfg_t         cfg_q, cfg_d;
   logic [FW-1:0]     frames_q, frames_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic              busy_q;
   logic              done_q, done_d;

   logic              run_c;
   logic              wrap_c;
   logic              accept_c;
   logic [DUTY_W-1:0] stepped_c;

   pwm_frame_timer #(
      .CLK_PERIOD (CLK_PERIOD)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable),
      .run_o         (run_c),
      .frame_start_o (frame_start),
      .wrap_c_o      (wrap_c)
   );

   assign cmd_ready = run_c && enable && (state_q != ST_RAMP);
   assign accept_c  = cmd_valid && cmd_ready;
   assign stepped_c = step_toward(duty_q, cfg_q.target, cfg_q.step);

   // Next-state and datapath: enable low aborts, accept starts a ramp,
   // frame wraps in RAMP count frames and apply steps.
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      cfg_d    = cfg_q;
      frames_d = frames_q;
      fcnt_d   = fcnt_q;
      done_d   = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         fcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (accept_c) begin
                  cfg_d.target = (cmd_target > DUTY_W'(CLK_PERIOD)) ? DUTY_W'(CLK_PERIOD)
                                                                    : cmd_target;
                  cfg_d.step   = cmd_step;
                  frames_d     = (cmd_frames == '0) ? FW'(1) : cmd_frames;
                  fcnt_d       = '0;
                  state_d      = ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (wrap_c) begin
                  // Already at target or a jump finishes at this wrap.
                  if ((duty_q == cfg_q.target) || (cfg_q.step == '0) ||
                      ((fcnt_q + FW'(1)) == frames_q)) begin
                     fcnt_d = '0;
                     duty_d = stepped_c;
                     if (stepped_c == cfg_q.target) begin
                        done_d  = 1'b1;
                        state_d = ST_HOLD;
                     end
                  end else begin
                     fcnt_d = fcnt_q + FW'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         cfg_q    <= '0;
         frames_q <= '0;
         fcnt_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         cfg_q    <= cfg_d;
         frames_q <= frames_d;
         fcnt_q   <= fcnt_d;
         busy_q   <= (state_d == ST_RAMP);
         done_q   <= done_d;
      end
   end

   assign duty   = duty_q;
   assign pwm_en = run_c;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter CLK_PERIOD, default 1000, meaning PWM frame length in clk cycles (>=2).
REQ-002 SHALL have parameter FW, default 16, meaning width of the frames-per-step field.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, meaning run control; low aborts any ramp and stops the frame timer.
REQ-006 SHALL have port cmd_valid, input, 1, meaning ramp command offered.
REQ-007 SHALL have port cmd_ready, output, 1, meaning command can be accepted this cycle.
REQ-008 SHALL have port cmd_target, input, 32, meaning final duty in clk cycles.
REQ-009 SHALL have port cmd_step, input, 32, meaning duty increment/decrement per step.
REQ-010 SHALL have port cmd_frames, input, FW, meaning PWM frames between steps.
REQ-011 SHALL have port duty, output, 32, meaning duty value driving the PWM pwm_period input.
REQ-012 SHALL have port pwm_en, output, 1, meaning enable driving the PWM enable input.
REQ-013 SHALL have port frame_start, output, 1, meaning one-cycle pulse when the frame counter is 0.
REQ-014 SHALL have port busy, output, 1, meaning high in state RAMP.
REQ-015 SHALL have port done, output, 1, meaning one-cycle pulse when duty reaches target.

Function
REQ-016 SHALL run frame counter 0..CLK_PERIOD-1, wrapping to 0, while enable=1; held at 0 while enable=0.
REQ-017 SHALL assert frame_start in every enabled cycle with frame counter = 0.
REQ-018 SHALL drive pwm_en = enable, registered (1 cycle latency), aligned so the PWM's own counter matches the frame counter.
REQ-019 SHALL implement FSM states IDLE, RAMP, HOLD.
REQ-020 SHALL assert cmd_ready in IDLE and HOLD when enable=1; handshake completes on cmd_valid & cmd_ready.
REQ-021 SHALL on accept latch target = min(cmd_target, CLK_PERIOD), step, frames = max(cmd_frames, 1); go to RAMP.
REQ-022 SHALL count frames at frame counter wrap (CLK_PERIOD-1 -> 0); apply one step when the count reaches frames, then reload it.
REQ-023 SHALL update duty only at frame wrap, so no PWM frame sees a mid-frame duty change.
REQ-024 SHALL step upward as duty = min(duty+step, target), computed 33-bit wide, no overflow wrap.
REQ-025 SHALL step downward as duty = max(duty-step, target), computed 33-bit wide, no underflow wrap.
REQ-026 SHALL treat step = 0 as a jump: duty = target at the next frame wrap.
REQ-027 SHALL, when duty = target after an update, pulse done for one cycle and enter HOLD.
REQ-028 SHALL, when an accepted target equals the current duty, pulse done at the next frame wrap without changing duty.
REQ-029 SHALL, on enable low in any state, enter IDLE next cycle, keep duty value, clear frame/step counters, drop pwm_en.
REQ-030 SHALL give enable low priority over a same-cycle cmd_valid; no command accepted.
REQ-031 SHALL, when frame wrap and command accept coincide in HOLD, accept the command; its first step occurs after the full frames count.

Reset
REQ-032 SHALL on rst_n low asynchronously set: state IDLE; duty 0; pwm_en 0; frame_start, busy, done 0; all counters 0.
REQ-033 SHALL, on reset mid-ramp, discard the command; operation restarts only after a new command post-release.
REQ-034 SHALL deassert reset synchronously to clk (external synchronizer); no outputs change before the first post-release edge.

Structure
REQ-035 SHALL place the state enum, duty width (32) and the step-arithmetic clamp helper in shared package pwm_ctrl_pkg.
REQ-036 SHALL implement the frame counter, frame_start and wrap strobe as sub-module pwm_frame_timer, shared with the PWM instance.
REQ-037 SHALL be sized at 120-400 RTL lines; no multipliers or dividers.

Verification
REQ-038 SHALL test upward ramp: CLK_PERIOD=10, duty 0, cmd target=7, step=2, frames=1 -> duty 2,4,6,7 at successive wraps; done once; HOLD.
REQ-039 SHALL test downward ramp with frames: duty 7, target=1, step=3, frames=2 -> duty 4 after 2 wraps, 1 after 4 wraps; done.
REQ-040 SHALL test clamps: target=50 (CLK_PERIOD=10) -> latched 10; step=0xFFFFFFFF upward from 0 -> duty 10, no wrap.
REQ-041 SHALL test abort: enable low mid-ramp at duty 4 -> IDLE next cycle, duty stays 4, pwm_en 0, cmd_ready 0.
REQ-042 SHALL test busy rejection: cmd_valid held during RAMP -> cmd_ready 0, no accept until HOLD.
REQ-043 SHALL test reset: rst_n pulsed low mid-cycle during RAMP -> all outputs 0 immediately, before any clk edge.
